sigmoid_pipe: RTL and testbench
===============================

Name: sigmoid_pipe

Overview:
- Pipelined, parametrised piecewise-linear (PWL) activation unit for the neural datapath. It is the successor to the combinational fixed-point sigmoid.
- Accepts one signed fixed-point sample per cycle under valid/ready handshake. Returns sigmoid(x) or tanh(x) in the same format, 3 cycles later.
- A sideband tag travels with each sample so that downstream neuron accumulators can match results to sources.

Parameters:
- WIDTH, 32, total bits of input and output; two's complement; legal range 16..64.
- FRAC, 16, fractional bits (value = int / 2^FRAC); FRAC >= 5 and FRAC <= WIDTH-4.
- TAG_W, 4, sideband tag width; legal range 1..16.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  unit can accept a sample this cycle
- in_data  in  WIDTH  signed fixed-point x
- in_mode  in  1  0 = sigmoid, 1 = tanh; sampled with in_data
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  signed fixed-point result
- out_tag  out  TAG_W  tag of the sample that produced out_data

Behaviour:
- Reset:
  - The clock is single; reset is synchronous and active-low.
  - On any clk edge with rst_n=0, all stage valid bits, out_valid, out_data and out_tag clear to 0.
  - Samples in flight are discarded; there is no partial output after reset.
  - in_ready=1 from the first cycle after reset release.
- Flow control:
  - advance = ~out_valid | out_ready.
  - All three stages shift together when advance=1 and hold otherwise.
  - in_ready = advance. This is a combinational path from out_ready; it is documented and accepted.
  - A transfer occurs on (valid & ready) at either port.
  - While out_valid=1 and out_ready=0, out_data and out_tag remain stable.
- Latency: an accepted sample appears on out_valid exactly 3 cycles later if out_ready is held 1. Throughput is 1 sample per cycle. Order is preserved.
- Stage 1 (absolute value and mode):
  - a = |x|. For x = -2^(WIDTH-1), a saturates to 2^(WIDTH-1)-1.
  - tanh mode: a = min(2a, 2^(WIDTH-1)-1), saturating.
  - Register a, sign(x), mode, tag, valid.
- Stage 2 (segment select and slope): using ONE = 2^FRAC, select on a:
  - a < 1.0 (ONE): slope 2^-2, intercept 0.5.
  - a < 2.375 (19 << (FRAC-3)): slope 2^-3, intercept 0.625.
  - a < 5.0 (5 << FRAC): slope 2^-5, intercept 0.84375 (27 << (FRAC-5)).
  - Otherwise: slope 0, intercept 1.0.
  - Boundary values belong to the upper segment.
  - Slope product = a >> k (logical shift; a is non-negative; truncates). No hardware multiplier is used.
  - Register product, intercept, sign, mode, tag, valid.
- Stage 3 (combine and fold):
  - s = product + intercept; s is always in [0.5, 1.0].
  - sigmoid: y = s for x >= 0, y = ONE - s for x < 0.
  - tanh: t = 2s - ONE; y = t for x >= 0, y = -t for x < 0.
  - Register y to out_data.
- Width rule: all internal arithmetic uses WIDTH bits. No intermediate overflows, given the constraint FRAC <= WIDTH-4.
- Simultaneous events:
  - Input accept and output drain in the same cycle are legal and required for full throughput.
  - rst_n=0 overrides all handshakes.
- x = 0:
  - sigmoid gives exactly 0.5.
  - tanh gives exactly 0 (+0; the sign fold of 0 gives 0).

Decomposition:
- Package neural_fixed_pkg holds:
  - act_mode_t enum (ACT_SIGMOID=0, ACT_TANH=1).
  - Functions returning the FRAC-scaled breakpoints, intercepts and shift amounts, so other activation blocks reuse identical constants.
- Sub-module pwl_segment_eval: combinational; input a, output product and intercept. It is instantiated in stage 2 and is independently testable.

Test Plan:
All cases use WIDTH=32, FRAC=16.
- Reset and basic latency: release rst_n, keep out_ready=1, send x=0x0000_0000 in sigmoid mode at cycle 0 -> out_valid at cycle 3, out_data=0x0000_8000, tag echoed.
- Segments and sign, sigmoid mode:
  - x=0x0001_8000 (1.5) -> 0x0000_D000.
  - x=0xFFFE_8000 (-1.5) -> 0x0000_3000.
  - x=0x0003_0000 (3.0) -> 0x0000_F000.
  - x=0x0001_0000 (boundary) -> 0x0000_C000.
- Saturation:
  - x=0x7FFF_FFFF -> 0x0001_0000.
  - x=0x8000_0000 -> 0x0000_0000.
  - tanh x=0x4000_0000 -> 0x0001_0000.
- tanh mode:
  - x=0x0000_4000 (0.25) -> 0x0000_4000.
  - x=0xFFFF_C000 -> 0xFFFF_C000.
  - x=0 -> 0.
- Backpressure: stream 6 tagged samples back-to-back, hold out_ready=0 for 5 cycles mid-stream.
  - in_ready drops once the pipeline is full.
  - out_data and out_tag remain stable while stalled.
  - After release, all 6 results arrive in order with no loss or duplication.
- Reset mid-operation: assert rst_n=0 for 1 cycle with 3 samples in flight -> out_valid=0 on the next cycle; no stale result emerges afterward; a new sample after release returns correctly at latency 3.

Source files
------------

// File: rtl/neural_fixed_pkg.sv
// rtl/neural_fixed_pkg.sv - shared fixed-point activation types and PWL constants
package neural_fixed_pkg;

    typedef enum logic {
        ACT_SIGMOID = 1'b0,
        ACT_TANH    = 1'b1
    } act_mode_t;

    localparam int PWL_SEGMENTS = 4;

    function automatic logic [63:0] pwl_one(input int frac);
        return 64'd1 << frac;
    endfunction

    // Upper bound (exclusive) of segment seg; the last segment is unbounded.
    function automatic logic [63:0] pwl_breakpoint(input int seg, input int frac);
        case (seg)
            0:       return 64'd1  << frac;
            1:       return 64'd19 << (frac - 3);
            2:       return 64'd5  << frac;
            default: return '1;
        endcase
    endfunction

    function automatic logic [63:0] pwl_intercept(input int seg, input int frac);
        case (seg)
            0:       return 64'd1  << (frac - 1);
            1:       return 64'd5  << (frac - 3);
            2:       return 64'd27 << (frac - 5);
            default: return 64'd1  << frac;
        endcase
    endfunction

    function automatic int pwl_shift(input int seg);
        case (seg)
            0:       return 2;
            1:       return 3;
            2:       return 5;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/pwl_segment_eval.sv
// rtl/pwl_segment_eval.sv - combinational PWL segment select, shift-slope product and intercept
module pwl_segment_eval
    import neural_fixed_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] intercept
);

    localparam logic [WIDTH-1:0] BP0 = WIDTH'(pwl_breakpoint(0, FRAC));
    localparam logic [WIDTH-1:0] BP1 = WIDTH'(pwl_breakpoint(1, FRAC));
    localparam logic [WIDTH-1:0] BP2 = WIDTH'(pwl_breakpoint(2, FRAC));
    localparam logic [WIDTH-1:0] IC0 = WIDTH'(pwl_intercept(0, FRAC));
    localparam logic [WIDTH-1:0] IC1 = WIDTH'(pwl_intercept(1, FRAC));
    localparam logic [WIDTH-1:0] IC2 = WIDTH'(pwl_intercept(2, FRAC));
    localparam logic [WIDTH-1:0] IC3 = WIDTH'(pwl_intercept(3, FRAC));

    // a is non-negative, so a logical shift is the truncating slope multiply.
    always_comb begin
        product   = '0;
        intercept = IC3;
        if (a < BP0) begin
            product   = a >> pwl_shift(0);
            intercept = IC0;
        end else if (a < BP1) begin
            product   = a >> pwl_shift(1);
            intercept = IC1;
        end else if (a < BP2) begin
            product   = a >> pwl_shift(2);
            intercept = IC2;
        end
    end

endmodule

// File: rtl/sigmoid_pipe.sv
// rtl/sigmoid_pipe.sv - 3-stage pipelined PWL sigmoid/tanh with tag sideband and valid/ready flow control
module sigmoid_pipe
    import neural_fixed_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(pwl_one(FRAC));

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic             s1_neg_q, s1_neg_d;
    act_mode_t        s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_prod_q, s2_prod_d;
    logic [WIDTH-1:0] s2_icpt_q, s2_icpt_d;
    logic             s2_neg_q, s2_neg_d;
    act_mode_t        s2_mode_q, s2_mode_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             advance;
    logic [WIDTH-1:0] abs_x, mag_x;
    logic [WIDTH-1:0] pwl_prod, pwl_icpt;
    logic [WIDTH-1:0] sum, tanh_t, y;

    assign advance   = ~out_valid_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

    // Stage 1: saturating magnitude; tanh(x) is evaluated as 2*sigmoid(2x)-1.
    always_comb begin
        if (!in_data[WIDTH-1]) begin
            abs_x = in_data;
        end else if (in_data == MIN_NEG) begin
            abs_x = MAX_POS;
        end else begin
            abs_x = -in_data;
        end
        mag_x = abs_x;
        if (act_mode_t'(in_mode) == ACT_TANH) begin
            mag_x = abs_x[WIDTH-2] ? MAX_POS : {abs_x[WIDTH-2:0], 1'b0};
        end
    end

    pwl_segment_eval #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_pwl (
        .a         (s1_a_q),
        .product   (pwl_prod),
        .intercept (pwl_icpt)
    );

    // Stage 3: s lies in [0.5, 1.0], so folds never overflow.
    always_comb begin
        sum    = s2_prod_q + s2_icpt_q;
        tanh_t = {sum[WIDTH-2:0], 1'b0} - ONE;
        if (s2_mode_q == ACT_TANH) begin
            y = s2_neg_q ? -tanh_t : tanh_t;
        end else begin
            y = s2_neg_q ? (ONE - sum) : sum;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_neg_d    = s1_neg_q;
        s1_mode_d   = s1_mode_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_prod_d   = s2_prod_q;
        s2_icpt_d   = s2_icpt_q;
        s2_neg_d    = s2_neg_q;
        s2_mode_d   = s2_mode_q;
        s2_tag_d    = s2_tag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d    = mag_x;
                s1_neg_d  = in_data[WIDTH-1];
                s1_mode_d = act_mode_t'(in_mode);
                s1_tag_d  = in_tag;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_d = pwl_prod;
                s2_icpt_d = pwl_icpt;
                s2_neg_d  = s1_neg_q;
                s2_mode_d = s1_mode_q;
                s2_tag_d  = s1_tag_q;
            end
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d = y;
                out_tag_d  = s2_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_neg_q    <= 1'b0;
            s1_mode_q   <= ACT_SIGMOID;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_icpt_q   <= '0;
            s2_neg_q    <= 1'b0;
            s2_mode_q   <= ACT_SIGMOID;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_neg_q    <= s1_neg_d;
            s1_mode_q   <= s1_mode_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_icpt_q   <= s2_icpt_d;
            s2_neg_q    <= s2_neg_d;
            s2_mode_q   <= s2_mode_d;
            s2_tag_q    <= s2_tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// tb/tb_sigmoid_pipe.sv - self-checking bench for sigmoid_pipe against a plain-arithmetic reference
module tb_sigmoid_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    int tests = 0;
    int fails = 0;
    logic [35:0] exp_q[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_tag;
    bit          rand_done;

    logic [31:0] tv_x   [10] = '{32'h0001_8000, 32'hFFFE_8000, 32'h0003_0000, 32'h0001_0000,
                                 32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'h0000_4000,
                                 32'hFFFF_C000, 32'h0000_0000};
    logic        tv_m   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] tv_exp [10] = '{32'h0000_D000, 32'h0000_3000, 32'h0000_F000, 32'h0000_C000,
                                 32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_4000,
                                 32'hFFFF_C000, 32'h0000_0000};
    longint      bps    [6]  = '{65536, 155648, 327680, 32768, 77824, 163840};

    sigmoid_pipe #(.WIDTH(32), .FRAC(16), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] x, input bit is_tanh);
        longint one = 65536;
        longint xv  = longint'($signed(x));
        longint lim = 64'sd2147483647;
        longint a, s, y;
        a = (xv < 0) ? -xv : xv;
        if (a > lim) a = lim;
        if (is_tanh) begin
            a = 2 * a;
            if (a > lim) a = lim;
        end
        if (a < one)                 s = a / 4 + one / 2;
        else if (8 * a < 19 * one)   s = a / 8 + (5 * one) / 8;
        else if (a < 5 * one)        s = a / 32 + (27 * one) / 32;
        else                         s = one;
        y = is_tanh ? (2 * s - one) : s;
        if (xv < 0) y = is_tanh ? -y : (one - y);
        return y[31:0];
    endfunction

    function automatic logic [31:0] rand_x();
        logic [31:0] x;
        longint v;
        case ($urandom_range(0, 3))
            0: x = $urandom;
            1: x = $urandom_range(0, 32'h000A_0000) - 32'h0005_0000;
            2: begin
                v = bps[$urandom_range(0, 5)] + longint'($urandom_range(0, 2)) - 1;
                if ($urandom_range(0, 1) == 1) v = -v;
                x = v[31:0];
            end
            default: x = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF - $urandom_range(0, 3);
        endcase
        return x;
    endfunction

    // Drives one sample and waits (bounded) for acceptance; the expected result is queued on accept.
    task automatic send(input logic [31:0] x, input logic m, input logic [3:0] t, input logic [31:0] expv);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        in_mode  = m;
        in_tag   = t;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(ok), 64'd1);
        if (ok) begin
            exp_q.push_back({t, expv});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic latency_check(input logic [31:0] x, input logic m, input logic [3:0] t, input logic [31:0] expv);
        send(x, m, t, expv);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("latency_valid_c%0d", c), 64'(out_valid), 64'(c == 3));
        end
        check("latency_data", 64'(out_data), 64'(expv));
        check("latency_tag", 64'(out_tag), 64'(t));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        logic [35:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (prev_stall) begin
                check("stall_data_stable", 64'(out_data), 64'(prev_data));
                check("stall_tag_stable", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                check("out_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e[31:0]));
                    check("out_tag", 64'(out_tag), 64'(e[35:32]));
                end
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_data  = out_data;
        prev_tag   = out_tag;
    end

    initial begin
        logic [31:0] x;
        logic        m;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic latency, sigmoid(0)
        latency_check(32'h0, 1'b0, 4'h5, 32'h0000_8000);

        // Directed segment, sign and saturation vectors, back-to-back
        for (int i = 0; i < 10; i++) send(tv_x[i], tv_m[i], 4'(i), tv_exp[i]);
        drain();

        // Backpressure: 6 tagged samples with a 5-cycle stall mid-stream
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    x = rand_x();
                    m = 1'($urandom_range(0, 1));
                    send(x, m, 4'(i), model(x, m));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 64'(in_ready), 64'd0);
                    check("bp_out_valid_held", 64'(out_valid), 64'd1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Randomised traffic with random downstream backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    x = rand_x();
                    m = 1'($urandom_range(0, 1));
                    send(x, m, 4'($urandom), model(x, m));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            x = rand_x();
            send(x, 1'b0, 4'(8 + i), model(x, 1'b0));
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        latency_check(32'hFFFE_8000, 1'b0, 4'hC, 32'h0000_3000);
        latency_check(32'h0000_0000, 1'b1, 4'hD, 32'h0000_0000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
